// File: rtl/seg_display_mux.sv
// ============================================================================
// Module   : seg_display_mux
// Brief    : 4-digit active-low 7-segment driver for the CORDIC result/status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        err_in,
    input  logic        busy,
    output logic [3:0]  anodeOutput,
    output logic [7:0]  cathodeOutput,
    output logic [1:0]  disp_state
);

    localparam logic [1:0] ST_BLANK = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_SHOW  = 2'b10;
    localparam logic [1:0] ST_ERROR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_E    = 8'h86;
    localparam logic [7:0] SEG_R    = 8'hAF;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [15:0]      val_q;
    logic [3:0]       anode_q, anode_d;
    logic [7:0]       cathode_q, cathode_d;
    logic [3:0]       nibble;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: load beats busy; dropping busy never returns to BLANK
    always_comb begin
        state_d = state_q;
        if (load && !err_in) begin
            state_d = ST_SHOW;
        end else if (load && err_in) begin
            state_d = ST_ERROR;
        end else if (busy) begin
            state_d = ST_BUSY;
        end
    end

    // Refresh counter, digit index and latched value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
            val_q <= 16'h0000;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (load && !err_in) begin
                val_q <= data_in;
            end
        end
    end

    assign nibble = val_q[idx_q*4 +: 4];

    // Output decode from current state, index and value
    always_comb begin
        anode_d   = ~(4'b0001 << idx_q);
        cathode_d = SEG_OFF;
        case (state_q)
            ST_SHOW:  cathode_d = hex_seg(nibble);
            ST_BUSY:  cathode_d = SEG_DASH;
            ST_ERROR: begin
                case (idx_q)
                    2'd3:        cathode_d = SEG_E;
                    2'd2, 2'd1:  cathode_d = SEG_R;
                    default:     cathode_d = SEG_OFF;
                endcase
            end
            default: begin
                anode_d   = 4'b1111;
                cathode_d = SEG_OFF;
            end
        endcase
    end

    // Output register: one cycle behind state/index/value
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q   <= 4'b1111;
            cathode_q <= SEG_OFF;
        end else begin
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anodeOutput   = anode_q;
    assign cathodeOutput = cathode_q;
    assign disp_state    = state_q;

endmodule

`default_nettype wire
